// File: rtl/multiword_add_seq.sv
// Multi-word add/subtract, one operand word per beat, least-significant word first.
// Latency: one cycle from an accepted beat to its registered result beat.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds every out_* stable.
module multiword_add_seq #(
  parameter int N    = 8,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic            in_first,
  input  logic            in_last,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_sum,
  output logic            out_cout,
  output logic            out_last,
  output logic            out_ovf,
  output logic [IDXW-1:0] out_idx,
  output logic            out_restart
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic            carry, mode;
  logic [IDXW-1:0] idx;

  logic            accept, first_beat, mode_eff, cin, ovf, restart;
  logic [N-1:0]    b_adj;
  logic [N:0]      word;
  logic [IDXW-1:0] idx_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt  = state;
    first_beat = in_first || (state == IDLE);
    mode_eff   = first_beat ? in_sub : mode;
    // Subtraction is A + ~B + 1: the +1 is the carry-in of the first word.
    cin        = first_beat ? in_sub : carry;
    b_adj      = mode_eff ? ~in_b : in_b;
    word       = {1'b0, in_a} + {1'b0, b_adj} + {{N{1'b0}}, cin};
    idx_nxt    = first_beat ? '0 : idx + IDXW'(1);
    ovf        = in_last && (in_a[N-1] == b_adj[N-1]) && (word[N-1] != in_a[N-1]);
    restart    = in_first && (state == RUN);
    if (accept) begin
      state_nxt = in_last ? IDLE : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry       <= 1'b0;
      mode        <= 1'b0;
      idx         <= '0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_cout    <= 1'b0;
      out_last    <= 1'b0;
      out_ovf     <= 1'b0;
      out_idx     <= '0;
      out_restart <= 1'b0;
    end else if (accept) begin
      carry       <= word[N];
      mode        <= mode_eff;
      idx         <= idx_nxt;
      out_valid   <= 1'b1;
      out_sum     <= word[N-1:0];
      out_cout    <= word[N];
      out_last    <= in_last;
      out_ovf     <= ovf;
      out_idx     <= idx_nxt;
      out_restart <= restart;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq: the driver queues hand-computed results,
// a monitor pops and compares each result beat as it is consumed.
module tb_multiword_add_seq;

  localparam int N    = 8;
  localparam int IDXW = 4;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       last;
    logic       ovf;
    logic [3:0] idx;
    logic       restart;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_a, in_b;
  logic            in_first, in_last, in_sub;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_sum;
  logic            out_cout, out_last, out_ovf;
  logic [IDXW-1:0] out_idx;
  logic            out_restart;

  exp_t sb[$];
  exp_t got;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_acc    = 0;

  multiword_add_seq #(.N(N), .IDXW(IDXW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_first   (in_first),
    .in_last    (in_last),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_cout   (out_cout),
    .out_last   (out_last),
    .out_ovf    (out_ovf),
    .out_idx    (out_idx),
    .out_restart(out_restart)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign got = {out_sum, out_cout, out_last, out_ovf, out_idx, out_restart};

  function automatic exp_t mk(input logic [7:0] s, input logic c, input logic l,
                              input logic o, input logic [3:0] i, input logic r);
    return {s, c, l, o, i, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one beat; push its expected result at the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic f,
                      input logic l, input logic s, input exp_t e);
    bit ok = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_first = f; in_last = l; in_sub = s; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready stuck 0, required 1 (t=%0t)", $time);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #3;
      if (sb.size() == 0 && !out_valid) return;
    end
    vectors++; miscompares++;
    $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_beat: got %h, required no beat", got);
        end else begin
          e = sb.pop_front();
          chk("result_beat", 32'(got), 32'(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_b;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outputs", 32'({out_valid, got}), 32'(0));
    rst_n = 1'b1;
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    out_ready = 1'b1;

    // 0x01FF + 0x0001
    send(8'hFF, 8'h01, 1, 0, 0, mk(8'h00, 1, 0, 0, 4'd0, 0));
    send(8'h01, 8'h00, 0, 1, 0, mk(8'h02, 0, 1, 0, 4'd1, 0));
    // 0x0000 - 0x0001
    send(8'h00, 8'h01, 1, 0, 1, mk(8'hFF, 0, 0, 0, 4'd0, 0));
    send(8'h00, 8'h00, 0, 1, 0, mk(8'hFF, 0, 1, 0, 4'd1, 0));
    // single-word signed overflow, add and subtract
    send(8'h7F, 8'h01, 1, 1, 0, mk(8'h80, 0, 1, 1, 4'd0, 0));
    send(8'h80, 8'h01, 1, 1, 1, mk(8'h7F, 1, 1, 1, 4'd0, 0));
    // no in_first while idle still starts an operation
    send(8'h10, 8'h20, 0, 1, 0, mk(8'h30, 0, 1, 0, 4'd0, 0));
    // 17-word operation: index wraps
    for (int i = 0; i < 17; i++) begin
      logic [7:0] a;
      logic [3:0] ix;
      a  = 8'(i * 16);
      ix = i[3:0];
      send(a, 8'h0F, i == 0, i == 16, 0, mk(a + 8'h0F, 0, i == 16, 0, ix, 0));
    end

    // restart mid-operation discards the pending carry
    send(8'h00, 8'h00, 1, 0, 0, mk(8'h00, 0, 0, 0, 4'd0, 0));
    send(8'hFF, 8'h01, 0, 0, 0, mk(8'h00, 1, 0, 0, 4'd1, 0));
    send(8'h01, 8'h01, 1, 1, 0, mk(8'h02, 0, 1, 0, 4'd0, 1));
    send(8'h01, 8'h01, 1, 1, 0, mk(8'h02, 0, 1, 0, 4'd0, 0));

    // backpressure: three stalled cycles, then back-to-back
    drain();
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1, 0, 0, mk(8'h33, 0, 0, 0, 4'd0, 0));
    @(negedge clk);
    in_a = 8'h01; in_b = 8'h02; in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_out_valid", 32'(out_valid), 32'(1));
      chk("bp_hold", 32'(got), 32'(mk(8'h33, 0, 0, 0, 4'd0, 0)));
    end
    out_ready = 1'b1;
    @(posedge clk);
    sb.push_back(mk(8'h03, 0, 0, 0, 4'd1, 0));
    #1;
    t_b = cyc;
    in_valid = 1'b0;
    send(8'h04, 8'h04, 0, 1, 0, mk(8'h08, 0, 1, 0, 4'd2, 0));
    chk("b2b_accept_gap", 32'(last_acc - t_b), 32'(1));

    // reset between words 1 and 2 of a 3-word operation, result pending
    drain();
    send(8'hFF, 8'h01, 1, 0, 0, mk(8'h00, 1, 0, 0, 4'd0, 0));
    send(8'hFF, 8'h00, 0, 0, 0, mk(8'h00, 1, 0, 0, 4'd1, 0));
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk); #1;
    chk("midop_reset_outputs", 32'({out_valid, got}), 32'(0));
    rst_n = 1'b1;
    chk("midop_reset_in_ready", 32'(in_ready), 32'(1));
    out_ready = 1'b1;
    send(8'h05, 8'h03, 0, 1, 0, mk(8'h08, 0, 1, 0, 4'd0, 0));

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
